// File: rtl/config_write_sequencer_pkg.sv
// Shared definitions for the config write sequencer: FSM state encodings
// and the rule that decides whether a requested thread index is invalid.
package config_write_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_SLOT = 2'd1,
        ST_ISSUE     = 2'd2
    } state_t;

    // A thread index is rejected when it names a thread that does not exist.
    function automatic logic thread_out_of_range(input int unsigned thread,
                                                 input int unsigned count);
        return thread >= count;
    endfunction

endpackage

// File: rtl/config_write_sequencer_thread_slot_counter.sv
// Free-running round-robin thread slot counter. Exposes both the current
// slot and the slot it will hold next cycle so callers can schedule ahead.
module thread_slot_counter #(
    parameter int THREAD_COUNT       = 8,
    parameter int THREAD_COUNT_WIDTH = 3,
    parameter int INITIAL_THREAD     = 0
) (
    input  logic                          i_clock,
    input  logic                          i_clear,
    output logic [THREAD_COUNT_WIDTH-1:0] o_slot,
    output logic [THREAD_COUNT_WIDTH-1:0] o_slot_next
);

    localparam logic [THREAD_COUNT_WIDTH-1:0] LP_LAST  = THREAD_COUNT_WIDTH'(THREAD_COUNT - 1);
    localparam logic [THREAD_COUNT_WIDTH-1:0] LP_START = THREAD_COUNT_WIDTH'(INITIAL_THREAD);

    logic [THREAD_COUNT_WIDTH-1:0] r_slot;
    logic [THREAD_COUNT_WIDTH-1:0] w_slot_next;

    // Next slot: increment with wrap from the last thread back to 0.
    always_comb begin
        w_slot_next = r_slot + 1'b1;
        if (r_slot == LP_LAST) begin
            w_slot_next = '0;
        end
    end

    // Slot register: restarts at the configured initial thread on clear.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_slot <= LP_START;
        end else begin
            r_slot <= w_slot_next;
        end
    end

    assign o_slot      = r_slot;
    assign o_slot_next = w_slot_next;

endmodule

// File: rtl/config_write_sequencer.sv
// Config write sequencer: accepts one config write request for a given
// hardware thread and holds it until that thread's slot comes round, then
// issues the write for exactly one cycle.
//
// Handshake: a request is taken on any cycle where req_valid && req_ready.
// req_ready is high in IDLE and ISSUE (so writes can go back-to-back) and
// low while a request is waiting for its slot or while clear is asserted.
module config_write_sequencer
    import config_write_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH         = 0,
    parameter int WORD_WIDTH         = 0,
    parameter int THREAD_COUNT       = 8,
    parameter int THREAD_COUNT_WIDTH = 3,
    parameter int INITIAL_THREAD     = 0
) (
    input  logic                          clock,
    input  logic                          clear,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [THREAD_COUNT_WIDTH-1:0] req_thread,
    input  logic [ADDR_WIDTH-1:0]         req_addr,
    input  logic [WORD_WIDTH-1:0]         req_data,
    input  logic                          abort,
    output logic [ADDR_WIDTH-1:0]         config_addr,
    output logic [WORD_WIDTH-1:0]         config_data,
    output logic                          config_write,
    output logic [THREAD_COUNT_WIDTH-1:0] slot_thread,
    output logic                          req_error,
    output state_t                        dbg_state
);

    localparam logic [THREAD_COUNT_WIDTH-1:0] LP_START = THREAD_COUNT_WIDTH'(INITIAL_THREAD);

    logic [THREAD_COUNT_WIDTH-1:0] w_slot;
    logic [THREAD_COUNT_WIDTH-1:0] w_slot_next;
    logic                          w_ready;
    logic                          w_accept;
    logic                          w_out_of_range;

    state_t                        r_state;
    logic [THREAD_COUNT_WIDTH-1:0] r_held_thread;
    logic [ADDR_WIDTH-1:0]         r_held_addr;
    logic [WORD_WIDTH-1:0]         r_held_data;
    logic [ADDR_WIDTH-1:0]         r_config_addr;
    logic [WORD_WIDTH-1:0]         r_config_data;
    logic                          r_config_write;
    logic                          r_req_error;

    thread_slot_counter #(
        .THREAD_COUNT      (THREAD_COUNT),
        .THREAD_COUNT_WIDTH(THREAD_COUNT_WIDTH),
        .INITIAL_THREAD    (INITIAL_THREAD)
    ) u_slot_counter (
        .i_clock    (clock),
        .i_clear    (clear),
        .o_slot     (w_slot),
        .o_slot_next(w_slot_next)
    );

    assign w_ready        = !clear && (r_state == ST_IDLE || r_state == ST_ISSUE);
    assign w_accept       = req_valid && w_ready;
    assign w_out_of_range = thread_out_of_range(32'(req_thread), 32'(THREAD_COUNT));

    // Sequencer FSM with registered write strobe, address, data and error.
    // Entering ISSUE is decided one cycle early against slot_next, so the
    // write cycle always coincides with the target thread's slot.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state        <= ST_IDLE;
            r_held_thread  <= '0;
            r_held_addr    <= '0;
            r_held_data    <= '0;
            r_config_addr  <= '0;
            r_config_data  <= '0;
            r_config_write <= 1'b0;
            r_req_error    <= 1'b0;
        end else begin
            r_config_write <= 1'b0;
            r_config_addr  <= '0;
            r_config_data  <= '0;
            r_req_error    <= 1'b0;
            case (r_state)
                ST_WAIT_SLOT: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_slot_next == r_held_thread) begin
                        r_state        <= ST_ISSUE;
                        r_config_write <= 1'b1;
                        r_config_addr  <= r_held_addr;
                        r_config_data  <= r_held_data;
                    end
                end
                default: begin
                    // IDLE and ISSUE both accept; abort drops a same-cycle request.
                    if (w_accept && !abort) begin
                        if (w_out_of_range) begin
                            r_req_error <= 1'b1;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_held_thread <= req_thread;
                            r_held_addr   <= req_addr;
                            r_held_data   <= req_data;
                            if (w_slot_next == req_thread) begin
                                r_state        <= ST_ISSUE;
                                r_config_write <= 1'b1;
                                r_config_addr  <= req_addr;
                                r_config_data  <= req_data;
                            end else begin
                                r_state <= ST_WAIT_SLOT;
                            end
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Clear masks the outputs immediately so a pending write never escapes.
    assign req_ready    = w_ready;
    assign config_write = r_config_write && !clear;
    assign config_addr  = clear ? '0 : r_config_addr;
    assign config_data  = clear ? '0 : r_config_data;
    assign req_error    = r_req_error && !clear;
    assign slot_thread  = clear ? LP_START : w_slot;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_config_write_sequencer.sv
// Bench for config_write_sequencer with 8 threads and a 4-bit thread index.
module tb_config_write_sequencer;
    import config_write_sequencer_pkg::*;

    logic       clock = 1'b0;
    logic       clear;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_thread;
    logic [7:0] req_addr;
    logic [7:0] req_data;
    logic       abort;
    logic [7:0] config_addr;
    logic [7:0] config_data;
    logic       config_write;
    logic [3:0] slot_thread;
    logic       req_error;
    state_t     dbg_state;

    config_write_sequencer #(
        .ADDR_WIDTH        (8),
        .WORD_WIDTH        (8),
        .THREAD_COUNT      (8),
        .THREAD_COUNT_WIDTH(4),
        .INITIAL_THREAD    (0)
    ) dut (
        .clock       (clock),
        .clear       (clear),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_thread  (req_thread),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .abort       (abort),
        .config_addr (config_addr),
        .config_data (config_data),
        .config_write(config_write),
        .slot_thread (slot_thread),
        .req_error   (req_error),
        .dbg_state   (dbg_state)
    );

    // clock / reset block
    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    // monitor state (sampled mid-cycle)
    int         wr_cnt;
    int         wr_cyc;
    logic [3:0] wr_slot;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    int         err_cnt;
    int         err_cyc;
    int         idle_bad;

    always @(negedge clock) begin
        if (config_write) begin
            wr_cnt++;
            wr_cyc  = cyc;
            wr_slot = slot_thread;
            wr_addr = config_addr;
            wr_data = config_data;
        end else if (config_addr != 8'h00 || config_data != 8'h00) begin
            idle_bad++;
        end
        if (req_error) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic idle_cycles(input int n);
        req_valid = 1'b0;
        abort     = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset(input bit chk);
        req_valid = 1'b0;
        abort     = 1'b0;
        clear     = 1'b1;
        tick();
        tick();
        if (chk) begin
            @(negedge clock);
            check("rst_slot",  32'(slot_thread), 32'd0);
            check("rst_ready", 32'(req_ready), 32'd0);
            check("rst_write", 32'(config_write), 32'd0);
            check("rst_error", 32'(req_error), 32'd0);
            check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
            check("rst_addr",  32'({config_addr, config_data}), 32'd0);
            tick();
        end
        clear    = 1'b0;
        cyc      = 0;
        wr_cnt   = 0;
        wr_cyc   = -1;
        wr_slot  = '0;
        wr_addr  = '0;
        wr_data  = '0;
        err_cnt  = 0;
        err_cyc  = -1;
        idle_bad = 0;
    endtask

    // rdy_mode: 0 = not checked, 1 = low until the write cycle, 2 = always high
    typedef struct {
        logic [3:0] thread;
        logic [7:0] addr;
        logic [7:0] data;
        int         abort_at;
        int         clear_at;
        int         exp_wr;
        int         exp_lat;
        int         exp_err;
        int         exp_wait;
        int         rdy_mode;
    } vec_t;

    vec_t vecs[10];

    initial begin
        clear      = 1'b1;
        req_valid  = 1'b0;
        req_thread = '0;
        req_addr   = '0;
        req_data   = '0;
        abort      = 1'b0;

        //               thr    addr   data  abrt clr wr lat err wait rdy
        vecs[0] = '{4'd1, 8'h10, 8'hAB, -1, -1, 1, 1, 0, 0, 1};
        vecs[1] = '{4'd3, 8'h22, 8'h5C, -1, -1, 1, 3, 0, 2, 1};
        vecs[2] = '{4'd0, 8'h3F, 8'h01, -1, -1, 1, 8, 0, 7, 1};
        vecs[3] = '{4'd9, 8'h55, 8'h66, -1, -1, 0, 0, 1, 0, 2};
        vecs[4] = '{4'd7, 8'hFF, 8'hFF, -1, -1, 1, 7, 0, 6, 1};
        vecs[5] = '{4'd5, 8'h40, 8'h44,  2, -1, 0, 0, 0, 2, 0};
        vecs[6] = '{4'd4, 8'h80, 8'h88, -1,  2, 0, 0, 0, 2, 0};
        vecs[7] = '{4'd1, 8'h11, 8'h12,  1, -1, 1, 1, 0, 0, 1};
        vecs[8] = '{4'd2, 8'h33, 8'h34,  0, -1, 0, 0, 0, 0, 2};
        vecs[9] = '{4'd9, 8'hAA, 8'hBB,  0, -1, 0, 0, 0, 0, 2};

        do_reset(1'b1);

        for (int i = 0; i < 10; i++) begin
            int ready_bad;
            int wait_cnt;
            if (i != 0) do_reset(1'b0);
            req_thread = vecs[i].thread;
            req_addr   = vecs[i].addr;
            req_data   = vecs[i].data;
            req_valid  = 1'b1;
            abort      = (vecs[i].abort_at == 0);
            @(negedge clock);
            check($sformatf("v%0d_c0_ready", i), 32'(req_ready), 32'd1);
            check($sformatf("v%0d_c0_slot", i), 32'(slot_thread), 32'd0);
            ready_bad = 0;
            wait_cnt  = 0;
            for (int k = 1; k <= 12; k++) begin
                tick();
                req_valid = 1'b0;
                abort     = (k == vecs[i].abort_at);
                clear     = (k == vecs[i].clear_at);
                @(negedge clock);
                if (dbg_state == ST_WAIT_SLOT) wait_cnt++;
                if (vecs[i].rdy_mode == 1 && k < vecs[i].exp_lat && req_ready) ready_bad++;
                if (vecs[i].rdy_mode == 2 && !req_ready) ready_bad++;
                if (k == vecs[i].clear_at + 1) begin
                    check($sformatf("v%0d_post_clear_slot", i), 32'(slot_thread), 32'd0);
                    check($sformatf("v%0d_post_clear_ready", i), 32'(req_ready), 32'd1);
                end
            end
            clear = 1'b0;
            abort = 1'b0;
            check($sformatf("v%0d_wr_cnt", i), 32'(wr_cnt), 32'(vecs[i].exp_wr));
            check($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_wait_cycles", i), 32'(wait_cnt), 32'(vecs[i].exp_wait));
            check($sformatf("v%0d_ready_bad", i), 32'(ready_bad), 32'd0);
            check($sformatf("v%0d_idle_zero", i), 32'(idle_bad), 32'd0);
            if (vecs[i].exp_wr == 1) begin
                check($sformatf("v%0d_latency", i), 32'(wr_cyc), 32'(vecs[i].exp_lat));
                check($sformatf("v%0d_wr_slot", i), 32'(wr_slot), 32'(vecs[i].thread));
                check($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].addr));
                check($sformatf("v%0d_wr_data", i), 32'(wr_data), 32'(vecs[i].data));
            end
            if (vecs[i].exp_err == 1) begin
                check($sformatf("v%0d_err_cycle", i), 32'(err_cyc), 32'd1);
            end
        end

        // Back-to-back: thread 1 then thread 2 accepted during the ISSUE cycle.
        do_reset(1'b0);
        req_thread = 4'd1; req_addr = 8'h10; req_data = 8'h01; req_valid = 1'b1;
        tick();
        req_thread = 4'd2; req_addr = 8'h20; req_data = 8'h22; req_valid = 1'b1;
        @(negedge clock);
        check("b2b_ready_in_issue", 32'(req_ready), 32'd1);
        check("b2b_first_write", 32'(config_write), 32'd1);
        tick();
        idle_cycles(10);
        check("b2b_wr_cnt", 32'(wr_cnt), 32'd2);
        check("b2b_last_cyc", 32'(wr_cyc), 32'd2);
        check("b2b_last_slot", 32'(wr_slot), 32'd2);
        check("b2b_last_addr", 32'(wr_addr), 32'h20);
        check("b2b_last_data", 32'(wr_data), 32'h22);

        // Abort a waiting thread 5, then thread 6 is written exactly once.
        do_reset(1'b0);
        req_thread = 4'd5; req_addr = 8'h50; req_data = 8'h55; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clock);
        check("abort_state_idle", 32'(dbg_state), 32'(ST_IDLE));
        tick();
        req_thread = 4'd6; req_addr = 8'h66; req_data = 8'h67; req_valid = 1'b1;
        tick();
        idle_cycles(12);
        check("abort_then_wr_cnt", 32'(wr_cnt), 32'd1);
        check("abort_then_wr_cyc", 32'(wr_cyc), 32'd6);
        check("abort_then_wr_slot", 32'(wr_slot), 32'd6);
        check("abort_then_wr_addr", 32'(wr_addr), 32'h66);

        // Clear landing on the ISSUE cycle cancels the write.
        do_reset(1'b0);
        req_thread = 4'd2; req_addr = 8'h77; req_data = 8'h78; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        clear = 1'b1;
        @(negedge clock);
        check("clr_issue_write", 32'(config_write), 32'd0);
        check("clr_issue_ready", 32'(req_ready), 32'd0);
        tick();
        clear = 1'b0;
        @(negedge clock);
        check("clr_issue_slot_restart", 32'(slot_thread), 32'd0);
        idle_cycles(10);
        check("clr_issue_wr_cnt", 32'(wr_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/config_write_sequencer.md
CONFIG_WRITE_SEQUENCER -- requirements
Module: config_write_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 0, config address width (must be set by instantiator).
REQ-002 SHALL have parameter WORD_WIDTH, default 0, config data width.
REQ-003 SHALL have parameter THREAD_COUNT, default 8, number of hardware threads.
REQ-004 SHALL have parameter THREAD_COUNT_WIDTH, default 3, thread index width.
REQ-005 SHALL have parameter INITIAL_THREAD, default 0, slot counter value after reset.
REQ-006 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port clear  input  1  reset, synchronous and active-high.
REQ-008 SHALL have port req_valid  input  1  write request present.
REQ-009 SHALL have port req_ready  output  1  request accepted when req_valid && req_ready.
REQ-010 SHALL have port req_thread  input  THREAD_COUNT_WIDTH  target thread of the write.
REQ-011 SHALL have port req_addr  input  ADDR_WIDTH  config address (FC / IM / OD mapped range).
REQ-012 SHALL have port req_data  input  WORD_WIDTH  config data.
REQ-013 SHALL have port abort  input  1  drop any held, not-yet-issued request.
REQ-014 SHALL have port config_addr  output  ADDR_WIDTH  config address to the control path.
REQ-015 SHALL have port config_data  output  WORD_WIDTH  config data to the control path.
REQ-016 SHALL have port config_write  output  1  config write strobe.
REQ-017 SHALL have port slot_thread  output  THREAD_COUNT_WIDTH  thread currently occupying the config stage.
REQ-018 SHALL have port req_error  output  1  one-cycle pulse, request rejected (thread out of range).

Function
REQ-019 Slot counter SHALL advance by 1 every cycle and wrap from THREAD_COUNT-1 to 0; slot_next denotes the value it will hold next cycle.
REQ-020 States SHALL be IDLE, WAIT_SLOT, ISSUE.
REQ-021 req_ready SHALL be 1 in IDLE and ISSUE and 0 in WAIT_SLOT.
REQ-022 On accept with req_thread >= THREAD_COUNT: req_error SHALL pulse next cycle, no write, state -> IDLE.
REQ-023 On valid accept, the block SHALL latch thread/addr/data; state -> ISSUE if slot_next == req_thread, else -> WAIT_SLOT.
REQ-024 In WAIT_SLOT: when slot_next == held thread, state SHALL go to ISSUE; otherwise stay.
REQ-025 In ISSUE: config_write SHALL be 1 and config_addr/config_data SHALL equal the held values; slot_thread SHALL equal the held thread in that cycle.
REQ-026 In ISSUE without a new accept, state SHALL return to IDLE; with an accept, REQ-022/REQ-023 apply (back-to-back).
REQ-027 Outside ISSUE: config_write, config_addr and config_data SHALL be 0.
REQ-028 Accept-to-write latency SHALL be 1 to THREAD_COUNT cycles; exactly one write per accepted valid request.
REQ-029 abort in WAIT_SLOT SHALL return the block to IDLE with no write; abort in ISSUE SHALL NOT suppress the current write; abort in IDLE SHALL have no effect.
REQ-030 abort in the same cycle as an accept SHALL take priority: request dropped, no write, no error.

Reset
REQ-031 While clear=1: state IDLE, slot_thread = INITIAL_THREAD, held registers 0, config_write/config_addr/config_data/req_error 0, req_ready 0.
REQ-032 clear asserted mid WAIT_SLOT or ISSUE SHALL cancel the pending write; no write SHALL occur in the clear cycle.
REQ-033 First cycle after clear deasserts: slot_thread = INITIAL_THREAD, req_ready = 1.

Structure
REQ-034 State encodings and the out-of-range rule SHALL live in a shared localparam include, reused by the bench.
REQ-035 The wrapping slot counter SHALL be the sub-module thread_slot_counter (THREAD_COUNT, THREAD_COUNT_WIDTH, INITIAL_THREAD).

Verification (THREAD_COUNT=8, INITIAL_THREAD=0, accept at cycle with slot_thread=0)
REQ-036 req_thread=1, addr=0x10, data=0xAB -> config_write next cycle, slot_thread=1, addr 0x10, data 0xAB.
REQ-037 req_thread=3 -> WAIT_SLOT 2 cycles, config_write 3 cycles after accept with slot_thread=3.
REQ-038 req_thread=0 -> config_write 8 cycles after accept (full wrap), req_ready low throughout the wait.
REQ-039 req_thread=9 (THREAD_COUNT_WIDTH=4) -> req_error pulse next cycle, no config_write, req_ready stays 1.
REQ-040 req_thread=5, abort 2 cycles later -> no config_write; a following req_thread=6 is written exactly once.
REQ-041 req_thread=4, clear at cycle 2 -> no write; after clear, slot_thread restarts at 0.
